mem_arbiter: RTL and testbench

- Shares the single memory port between instruction fetch (IFU) and load/store (LSU) once the core moves from a combinational `inst` input to a handshaked memory.
- Accepts one request per master over valid/ready, forwards the winner to memory, and routes the response back to that master.
- Only one transaction is outstanding at a time.
- LSU has fixed priority; a starvation counter guarantees IFU progress.

---
 rtl/core_pkg.sv | 33 +++
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types for the core memory subsystem: arbiter state,
//               arbiter ownership and the memory request record.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Reference widths of the core memory port
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]   addr;
        logic                    wen;
        logic [MEM_DATA_W-1:0]   wdata;
        logic [MEM_DATA_W/8-1:0] wmask;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner selection between IFU and LSU. LSU has
//               fixed priority unless the IFU has been starved, in which case
//               a contested arbitration goes to the IFU.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick (
    input  logic i_ifu_valid,
    input  logic i_lsu_valid,
    input  logic i_starved,
    output logic o_grant_ifu,
    output logic o_grant_lsu
);

    // LSU wins unless the IFU is both requesting and starved; IFU takes the rest
    always_comb begin
        o_grant_lsu = i_lsu_valid && !(i_ifu_valid && i_starved);
        o_grant_ifu = i_ifu_valid && !o_grant_lsu;
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one handshaked memory port between instruction fetch
//               and load/store. One transaction outstanding at a time; the
//               response is routed back to the master that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                err
);

    localparam int                 c_MASK_W  = DATA_W / 8;
    localparam int                 c_CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_LIMIT);

    arb_state_t            r_state;
    arb_owner_t            r_owner;
    logic [c_CNT_W-1:0]    r_starve_cnt;
    logic                  r_err;
    logic                  r_mem_req_valid;
    logic [ADDR_W-1:0]     r_mem_req_addr;
    logic                  r_mem_req_wen;
    logic [DATA_W-1:0]     r_mem_req_wdata;
    logic [c_MASK_W-1:0]   r_mem_req_wmask;

    logic                  w_idle;
    logic                  w_starved;
    logic                  w_grant_ifu;
    logic                  w_grant_lsu;
    logic                  w_rsp_hit;

    assign w_idle    = (r_state == IDLE);
    assign w_starved = (r_starve_cnt == c_CNT_MAX);

    mem_arb_pick u_pick (
        .i_ifu_valid (ifu_req_valid),
        .i_lsu_valid (lsu_req_valid),
        .i_starved   (w_starved),
        .o_grant_ifu (w_grant_ifu),
        .o_grant_lsu (w_grant_lsu)
    );

    // Master handshakes: ready only while idle, response only to the owner
    always_comb begin
        ifu_req_ready = w_idle && w_grant_ifu;
        lsu_req_ready = w_idle && w_grant_lsu;
        w_rsp_hit     = (r_state == WAIT_RSP) && mem_rsp_valid;
        ifu_rsp_valid = w_rsp_hit && (r_owner == OWN_IFU);
        lsu_rsp_valid = w_rsp_hit && (r_owner == OWN_LSU);
        ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;
        lsu_rsp_data  = lsu_rsp_valid ? mem_rsp_data : '0;
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wen   = r_mem_req_wen;
    assign mem_req_wdata = r_mem_req_wdata;
    assign mem_req_wmask = r_mem_req_wmask;
    assign err           = r_err;

    // Transaction FSM with registered memory request and starvation tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_owner         <= OWN_IFU;
            r_starve_cnt    <= '0;
            r_err           <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wen   <= 1'b0;
            r_mem_req_wdata <= '0;
            r_mem_req_wmask <= '0;
        end else begin
            // A response outside WAIT_RSP (including the REQ accept cycle) is a protocol error
            if (mem_rsp_valid && (r_state != WAIT_RSP)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant_lsu) begin
                        r_state         <= REQ;
                        r_owner         <= OWN_LSU;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_addr  <= lsu_req_addr;
                        r_mem_req_wen   <= lsu_req_wen;
                        r_mem_req_wdata <= lsu_req_wdata;
                        r_mem_req_wmask <= lsu_req_wmask;
                        // Only a contested LSU win counts towards IFU starvation
                        if (ifu_req_valid && !w_starved) begin
                            r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
                        end
                    end else if (w_grant_ifu) begin
                        r_state         <= REQ;
                        r_owner         <= OWN_IFU;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_addr  <= ifu_req_addr;
                        r_mem_req_wen   <= 1'b0;
                        r_mem_req_wdata <= '0;
                        r_mem_req_wmask <= '0;
                        r_starve_cnt    <= '0;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_state         <= WAIT_RSP;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A driver animates both
//               masters and a reactive memory, a transaction-level model
//               predicts grants and pushes expected requests/responses, and a
//               monitor pops and compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_s;

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        bit          chk;
    } rsp_s;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_req_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [3:0]  mem_req_wmask;
    logic        err;

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and bookkeeping
    int   n_checks = 0;
    int   n_fails  = 0;
    req_s exp_req[$];
    rsp_s exp_rsp[$];
    bit   grant_log[$];

    // Transaction-level model of the arbiter
    bit   model_busy = 0;
    int   model_cnt  = 0;
    bit   model_lsu  = 0;
    bit   model_wen  = 0;
    bit   rsp_was_driven = 0;
    bit   prev_rst = 1;

    // Stimulus knobs
    bit          rst_req = 1;
    bit          traffic_en = 0;
    bit          hold_ifu = 0, hold_lsu = 0;
    bit          log_en = 0;
    bit          ifu_done = 0, lsu_done = 0;
    bit          set_ifu = 0, set_lsu = 0;
    logic [31:0] set_ifu_addr, set_lsu_addr, set_lsu_wdata;
    logic        set_lsu_wen;
    logic [3:0]  set_lsu_wmask;
    int          ready_pct = 100;
    int          rsp_max = 1;
    int          rsp_cd = 0;
    bit          mem_rsp_en = 1;
    bit          inject_rsp = 0;
    bit          force_data = 0;
    logic [31:0] forced_data = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One clock cycle: drive memory and masters at negedge, then predict grants
    task automatic step();
        bit ifu_turn;
        bit win_ifu;
        bit win_lsu;
        @(negedge clk);
        rst = rst_req;
        if (prev_rst) begin
            model_busy = 0; model_cnt = 0; rsp_cd = 0; rsp_was_driven = 0;
            ifu_done = 0; lsu_done = 0;
            exp_req.delete(); exp_rsp.delete();
        end
        prev_rst = rst;
        if (rsp_was_driven) begin
            model_busy = 0;
            rsp_was_driven = 0;
        end

        mem_req_ready = ($urandom_range(99) < ready_pct);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = force_data ? forced_data : $urandom;
        if (inject_rsp) begin
            mem_rsp_valid = 1'b1;
            inject_rsp = 0;
        end else if (rsp_cd == 1) begin
            mem_rsp_valid = 1'b1;
            exp_rsp.push_back('{lsu: model_lsu, data: mem_rsp_data, chk: !model_wen});
            rsp_was_driven = 1;
        end
        if (rsp_cd > 0) rsp_cd--;

        if (ifu_done) begin ifu_req_valid = 1'b0; ifu_done = 0; end
        if (lsu_done) begin lsu_req_valid = 1'b0; lsu_done = 0; end
        if (set_ifu) begin
            ifu_req_valid = 1'b1; ifu_req_addr = set_ifu_addr; set_ifu = 0;
        end else if (hold_ifu && !ifu_req_valid) begin
            ifu_req_valid = 1'b1; ifu_req_addr = $urandom;
        end else if (traffic_en) begin
            if (!ifu_req_valid) begin
                if ($urandom_range(99) < 40) begin
                    ifu_req_valid = 1'b1; ifu_req_addr = $urandom;
                end
            end else if ($urandom_range(99) < 5) begin
                ifu_req_valid = 1'b0;
            end
        end
        if (set_lsu) begin
            lsu_req_valid = 1'b1; lsu_req_addr = set_lsu_addr; lsu_req_wen = set_lsu_wen;
            lsu_req_wdata = set_lsu_wdata; lsu_req_wmask = set_lsu_wmask; set_lsu = 0;
        end else if ((hold_lsu && !lsu_req_valid) ||
                     (traffic_en && !lsu_req_valid && $urandom_range(99) < 50)) begin
            lsu_req_valid = 1'b1; lsu_req_addr = $urandom; lsu_req_wen = 1'($urandom_range(1, 0));
            lsu_req_wdata = $urandom; lsu_req_wmask = 4'($urandom_range(15, 0));
        end else if (traffic_en && lsu_req_valid && !hold_lsu && $urandom_range(99) < 5) begin
            lsu_req_valid = 1'b0;
        end

        #1;
        win_ifu = 0;
        win_lsu = 0;
        if (!model_busy) begin
            ifu_turn = ifu_req_valid && (!lsu_req_valid || model_cnt >= STARVE_LIMIT);
            win_ifu  = ifu_turn;
            win_lsu  = lsu_req_valid && !ifu_turn;
        end
        check("ifu_req_ready", 64'(ifu_req_ready), 64'(win_ifu));
        check("lsu_req_ready", 64'(lsu_req_ready), 64'(win_lsu));
        if (log_en && ifu_req_ready) grant_log.push_back(1'b0);
        if (log_en && lsu_req_ready) grant_log.push_back(1'b1);
        if (win_ifu) begin
            exp_req.push_back('{addr: ifu_req_addr, wen: 1'b0, wdata: 32'h0, wmask: 4'h0});
            model_cnt = 0; model_lsu = 0; model_wen = 0; model_busy = 1; ifu_done = 1;
        end
        if (win_lsu) begin
            exp_req.push_back('{addr: lsu_req_addr, wen: lsu_req_wen, wdata: lsu_req_wdata,
                                wmask: lsu_req_wmask});
            if (ifu_req_valid && model_cnt < STARVE_LIMIT) model_cnt++;
            model_lsu = 1; model_wen = lsu_req_wen; model_busy = 1; lsu_done = 1;
        end
        if (mem_req_valid && mem_req_ready && mem_rsp_en) begin
            rsp_cd = int'($urandom_range(rsp_max, 1));
        end
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((model_busy || ifu_req_valid || lsu_req_valid || exp_req.size() != 0 ||
                exp_rsp.size() != 0 || rsp_cd != 0) && n < 200) begin
            step();
            n++;
        end
        check(name, 64'(n < 200), 64'(1));
    endtask

    // Monitor: compare memory requests and master responses against the scoreboard
    initial begin
        req_s e;
        rsp_s r;
        forever begin
            @(negedge clk);
            #2;
            if (mem_req_valid) begin
                if (exp_req.size() == 0) begin
                    check("mem_req_unexpected", 64'(mem_req_valid), 64'(0));
                end else begin
                    e = exp_req[0];
                    check("mem_req_addr", 64'(mem_req_addr), 64'(e.addr));
                    check("mem_req_fields", 64'({mem_req_wen, mem_req_wdata, mem_req_wmask}),
                          64'({e.wen, e.wdata, e.wmask}));
                    if (mem_req_ready) void'(exp_req.pop_front());
                end
            end
            if (exp_rsp.size() != 0) begin
                r = exp_rsp.pop_front();
                check("rsp_valid", 64'({ifu_rsp_valid, lsu_rsp_valid}), r.lsu ? 64'(1) : 64'(2));
                if (r.chk) check("rsp_data", 64'(r.lsu ? lsu_rsp_data : ifu_rsp_data), 64'(r.data));
            end else begin
                check("rsp_spurious", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int n;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = '0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;

        // Reset, then every output reads 0 with idle inputs
        step(); step();
        rst_req = 0;
        step();
        check("reset_outputs", 64'({ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready,
                                    lsu_rsp_valid, mem_req_valid, mem_req_wen, mem_req_wmask, err}), 64'(0));
        check("reset_outputs_wide", 64'({lsu_rsp_data, mem_req_addr}), 64'(0));
        check("reset_wdata", 64'(mem_req_wdata), 64'(0));

        // Test 1: single IFU fetch, zero-wait memory
        force_data = 1; forced_data = 32'h0000_0413;
        set_ifu = 1; set_ifu_addr = 32'h8000_0000;
        step();
        check("t1_ready_N", 64'(ifu_req_ready), 64'(1));
        step();
        check("t1_memreq_N1", 64'({mem_req_valid, mem_req_wen}), 64'(2));
        check("t1_addr_N1", 64'(mem_req_addr), 64'(32'h8000_0000));
        step();
        check("t1_rsp_N2", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(2));
        check("t1_data_N2", 64'(ifu_rsp_data), 64'(32'h0000_0413));
        force_data = 0;
        drain("t1_drain");

        // Test 2: simultaneous requests, LSU store wins, IFU granted at N+3
        set_ifu = 1; set_ifu_addr = 32'h8000_0040;
        set_lsu = 1; set_lsu_addr = 32'h8000_1000; set_lsu_wen = 1;
        set_lsu_wdata = 32'hDEAD_BEEF; set_lsu_wmask = 4'hF;
        step();
        check("t2_grant_N", 64'({ifu_req_ready, lsu_req_ready}), 64'(1));
        step();
        check("t2_store_N1", 64'({mem_req_valid, mem_req_wen, mem_req_wdata, mem_req_wmask}),
              64'({1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF}));
        check("t2_addr_N1", 64'(mem_req_addr), 64'(32'h8000_1000));
        step();
        check("t2_ack_N2", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(1));
        step();
        check("t2_ifu_N3", 64'({ifu_req_ready, lsu_req_ready}), 64'(2));
        drain("t2_drain");

        // Test 3: both masters held high, starvation limit forces IFU turns
        hold_ifu = 1; hold_lsu = 1; log_en = 1;
        n = 0;
        while (grant_log.size() < 10 && n < 80) begin step(); n++; end
        hold_ifu = 0; hold_lsu = 0; log_en = 0;
        check("t3_grant_count", 64'(grant_log.size() >= 10), 64'(1));
        for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
            check($sformatf("t3_grant_order[%0d]", i), 64'(grant_log[i]), 64'(pat[i]));
        end
        drain("t3_drain");

        // Test 4: memory stalls 5 cycles in REQ
        set_lsu = 1; set_lsu_addr = 32'h8000_2000; set_lsu_wen = 0;
        set_lsu_wdata = 32'h1234_5678; set_lsu_wmask = 4'h3;
        set_ifu = 1; set_ifu_addr = 32'h8000_0080;
        ready_pct = 0;
        step();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) ready_pct = 100;
            step();
            check("t4_stall", 64'({mem_req_valid, ifu_req_ready, lsu_req_ready}), 64'(4));
            check("t4_addr", 64'(mem_req_addr), 64'(32'h8000_2000));
            check("t4_fields", 64'({mem_req_wen, mem_req_wdata, mem_req_wmask}),
                  64'({1'b0, 32'h1234_5678, 4'h3}));
        end
        drain("t4_drain");

        // Test 5: reset during WAIT_RSP, then a late response
        mem_rsp_en = 0;
        set_ifu = 1; set_ifu_addr = 32'h8000_0100;
        step();
        step();
        rst_req = 1;
        step();
        rst_req = 0;
        mem_rsp_en = 1;
        step();
        step();
        inject_rsp = 1;
        step();
        set_ifu = 1; set_ifu_addr = 32'h8000_0104;
        step();
        check("t5_err", 64'(err), 64'(1));
        check("t5_idle_grant", 64'(ifu_req_ready), 64'(1));
        drain("t5_drain");
        check("t5_err_sticky", 64'(err), 64'(1));

        // Test 6: stray response in IDLE sets err until reset
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        check("t6_err_cleared", 64'(err), 64'(0));
        inject_rsp = 1;
        step();
        step();
        check("t6_err_set", 64'(err), 64'(1));
        repeat (5) step();
        check("t6_err_held", 64'(err), 64'(1));
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        check("t6_err_reset", 64'(err), 64'(0));

        // Randomized traffic with a stalling, variable-latency memory
        traffic_en = 1; ready_pct = 60; rsp_max = 3;
        repeat (2500) step();
        traffic_en = 0; ready_pct = 100;
        drain("rand_drain");
        check("rand_no_err", 64'(err), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
